// File: rtl/multicycle_ctrl_if.sv
// Handshake bundle between the multi-cycle controller and the RV32I datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
  parameter int ALU_CC_W = 4,
  parameter int CNT_W    = 16
);
  logic                run;
  logic [6:0]          opcode;
  logic [6:0]          funct7;
  logic [2:0]          funct3;
  logic                mem_ready;
  logic                ir_write;
  logic                pc_write;
  logic                reg_write;
  logic                mem2reg;
  logic                alu_src;
  logic                mem_write;
  logic                mem_read;
  logic [ALU_CC_W-1:0] alu_cc;
  logic                busy;
  logic                instr_done;
  logic                illegal;
  logic                mem_err;
  logic [CNT_W-1:0]    retired_cnt;

  modport master (
    input  run, opcode, funct7, funct3, mem_ready,
    output ir_write, pc_write, reg_write, mem2reg, alu_src, mem_write, mem_read,
           alu_cc, busy, instr_done, illegal, mem_err, retired_cnt
  );

  modport slave (
    output run, opcode, funct7, funct3, mem_ready,
    input  ir_write, pc_write, reg_write, mem2reg, alu_src, mem_write, mem_read,
           alu_cc, busy, instr_done, illegal, mem_err, retired_cnt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I-subset datapath,
// with memory-timeout trap, illegal-encoding skip and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int ALU_CC_W    = 4,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_if.master     bus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t           state;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] retired_cnt;
  logic             mem_err;

  logic is_load, is_store, is_mem, legal, retire;
  logic [3:0] cc;

  function automatic logic decode_legal(input logic [6:0] op, input logic [6:0] f7,
                                        input logic [2:0] f3);
    logic ok;
    case (op)
      OP_R:     ok = (f7 == 7'b0000000) ||
                     ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      OP_I: begin
        if (f3 == 3'b001)      ok = (f7 == 7'b0000000);
        else if (f3 == 3'b101) ok = (f7 == 7'b0000000) || (f7 == F7_ALT);
        else                   ok = 1'b1;
      end
      OP_LOAD:  ok = 1'b1;
      OP_STORE: ok = 1'b1;
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // funct7[5] only selects SUB for register-register ops; ADDI ignores it.
  function automatic logic [3:0] decode_cc(input logic [6:0] op, input logic [6:0] f7,
                                           input logic [2:0] f3);
    logic [3:0] c;
    if ((op == OP_LOAD) || (op == OP_STORE)) begin
      c = 4'b0010;
    end else begin
      case (f3)
        3'b000:  c = ((op == OP_R) && f7[5]) ? 4'b0110 : 4'b0010;
        3'b111:  c = 4'b0000;
        3'b110:  c = 4'b0001;
        3'b100:  c = 4'b0011;
        3'b010:  c = 4'b0111;
        3'b011:  c = 4'b1001;
        3'b001:  c = 4'b0100;
        3'b101:  c = f7[5] ? 4'b1000 : 4'b0101;
        default: c = 4'b0000;
      endcase
    end
    return c;
  endfunction

  // Instruction classification from the IR fields
  always_comb begin
    is_load  = (bus.opcode == OP_LOAD);
    is_store = (bus.opcode == OP_STORE);
    is_mem   = is_load || is_store;
    legal    = decode_legal(bus.opcode, bus.funct7, bus.funct3);
    cc       = decode_cc(bus.opcode, bus.funct7, bus.funct3);
    retire   = (state == S_WB) || ((state == S_MEM) && is_store && bus.mem_ready);
  end

  // State, memory wait counter, retired counter and sticky memory error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      wait_cnt    <= 8'd0;
      retired_cnt <= '0;
      mem_err     <= 1'b0;
    end else begin
      if (retire) retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      case (state)
        S_IDLE:   if (bus.run) state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          if (legal)        state <= S_EXEC;
          else if (bus.run) state <= S_FETCH;
          else              state <= S_IDLE;
        end
        S_EXEC: begin
          wait_cnt <= 8'd0;
          state    <= is_mem ? S_MEM : S_WB;
        end
        // A ready arriving in the last allowed cycle takes priority over the timeout.
        S_MEM: begin
          if (bus.mem_ready) begin
            if (is_load)      state <= S_WB;
            else if (bus.run) state <= S_FETCH;
            else              state <= S_IDLE;
          end else if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
            state   <= S_HALT;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WB:     state <= bus.run ? S_FETCH : S_IDLE;
        S_HALT:   state <= S_HALT;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Moore strobe decode from state and IR fields
  always_comb begin
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem2reg    = 1'b0;
    bus.alu_src    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.alu_cc     = '0;
    bus.illegal    = 1'b0;
    case (state)
      S_FETCH:  bus.ir_write = 1'b1;
      S_DECODE: begin
        if (!legal) begin
          bus.illegal  = 1'b1;
          bus.pc_write = 1'b1;
        end else begin
          bus.illegal  = 1'b0;
        end
      end
      S_EXEC: begin
        bus.alu_cc  = ALU_CC_W'(cc);
        bus.alu_src = (bus.opcode != OP_R);
      end
      S_MEM: begin
        bus.alu_cc    = ALU_CC_W'(cc);
        bus.alu_src   = 1'b1;
        bus.mem_read  = is_load;
        bus.mem_write = is_store;
        bus.pc_write  = retire;
      end
      S_WB: begin
        bus.alu_cc    = ALU_CC_W'(cc);
        bus.alu_src   = (bus.opcode != OP_R);
        bus.reg_write = 1'b1;
        bus.mem2reg   = is_load;
        bus.pc_write  = 1'b1;
      end
      default: bus.alu_cc = '0;
    endcase
    bus.instr_done  = retire;
    bus.busy        = (state != S_IDLE) && (state != S_HALT);
    bus.mem_err     = mem_err;
    bus.retired_cnt = retired_cnt;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing controller for the RV32I-subset datapath. It breaks each instruction into fetch, decode, execute, memory and write-back states, and drives the datapath control strobes from the decoded opcode/funct fields. It stalls on a data-memory ready handshake, traps illegal encodings and memory timeouts, and counts retired instructions. It sits beside `data_path`: it consumes `opcode`/`funct7`/`funct3` from the instruction register and drives `reg_write`, `mem2reg`, `alu_src`, `mem_write`, `mem_read` and `alu_cc`, plus the new `pc_write` and `ir_write` enables.

## Interface
- `ALU_CC_W`, 4, ALU control code width.
- `CNT_W`, 16, retired-instruction counter width.
- `MEM_TIMEOUT`, 15, maximum wait cycles for `mem_ready` in MEM (1..255).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; 1 = execute instructions, 0 = park in IDLE at the next instruction boundary.
- `opcode`  in  7  from instruction register.
- `funct7`  in  7  from instruction register.
- `funct3`  in  3  from instruction register.
- `mem_ready`  in  1  data memory has completed the current access.
- `ir_write`  out  1  latch instruction at PC into the IR.
- `pc_write`  out  1  PC <= PC+4 at this edge.
- `reg_write`  out  1  register file write enable.
- `mem2reg`  out  1  write-back select: 1 = memory data.
- `alu_src`  out  1  ALU B select: 1 = immediate.
- `mem_write`  out  1  data memory write strobe.
- `mem_read`  out  1  data memory read strobe.
- `alu_cc`  out  ALU_CC_W  ALU operation code.
- `busy`  out  1  state is not IDLE and not HALT.
- `instr_done`  out  1  one-cycle pulse when a legal instruction retires.
- `illegal`  out  1  one-cycle pulse when an illegal encoding is skipped.
- `mem_err`  out  1  sticky; set on memory timeout, cleared only by reset.
- `retired_cnt`  out  CNT_W  legal instructions retired since reset; wraps.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. The state register, counters and `mem_err` are the only flops. All outputs are Moore-decoded from the state and the IR fields, which are stable from DECODE onward.
- IDLE: if `run`=1, go to FETCH.
- FETCH: `ir_write`=1; go to DECODE.
- DECODE: classify the instruction.
  - Legal R (0110011), I-ALU (0010011), LOAD (0000011), STORE (0100011): go to EXEC.
  - Otherwise: `illegal`=1 and `pc_write`=1, then go to FETCH if `run`=1, else IDLE.
- Illegal encodings:
  - Unknown opcode.
  - R with `funct7` not 0000000/0100000, or with 0100000 and `funct3` not 000/101.
  - I-ALU with `funct3`=001 and `funct7`≠0.
  - I-ALU with `funct3`=101 and `funct7` not 0000000/0100000.
- EXEC: go to MEM for LOAD/STORE; go to WB for R/I-ALU.
- MEM: hold `mem_read` (LOAD) or `mem_write` (STORE) until `mem_ready`=1.
  - LOAD, on `mem_ready`: go to WB.
  - STORE, on `mem_ready`: retire in this cycle (`pc_write`=1, `instr_done`=1), then go to FETCH/IDLE per `run`.
  - Wait counter clears on MEM entry and increments each cycle with `mem_ready`=0.
  - If `mem_ready`=0 when the counter equals `MEM_TIMEOUT`-1: go to HALT and set `mem_err`. `mem_ready` arriving in that same cycle wins (no error).
- WB: `reg_write`=1 and `mem2reg`=(LOAD). Retire (`pc_write`=1, `instr_done`=1), then go to FETCH/IDLE per `run`.
- HALT: all strobes 0 and `busy`=0. Exit only via reset.
- `alu_src`=1 for I-ALU/LOAD/STORE during EXEC, MEM and WB; 0 otherwise.
- `alu_cc` is valid during EXEC, MEM and WB, and 0000 elsewhere.
  - LOAD/STORE: ADD 0010.
  - R/I decode by `funct3`: 000 ADD 0010 (SUB 0110 if R and `funct7[5]`); 111 AND 0000; 110 OR 0001; 100 XOR 0011; 010 SLT 0111; 011 SLTU 1001; 001 SLL 0100; 101 SRL 0101 (SRA 1000 if `funct7[5]`).
- `retired_cnt` increments on `instr_done` only and wraps from 2^CNT_W-1 to 0.
- `run` is sampled only at IDLE and at retirement. Deasserting `run` mid-instruction lets that instruction complete.

## Timing
- Reset asserted: state=IDLE immediately. All outputs are 0, including `retired_cnt`, `mem_err` and the wait counter. Reset mid-instruction aborts without retiring.
- Latency from FETCH to the retiring cycle:
  - R/I-ALU: 4 cycles.
  - STORE: 4+w cycles.
  - LOAD: 5+w cycles.
  - w = cycles with `mem_ready`=0 in MEM.
  - Illegal: 2 cycles.
- The retiring cycle is followed directly by FETCH; there are no bubbles.
- First FETCH occurs 1 cycle after `run` is seen high in IDLE.
- `pc_write`, `instr_done` and `illegal` are high for exactly one cycle per instruction, and are mutually exclusive with `ir_write`.

## Test plan
- Reset with `run`=0 -> all outputs 0, `busy`=0. Release reset and raise `run` -> `ir_write`=1 on the 2nd edge.
- R-type `funct7`=0100000, `funct3`=000 -> `alu_cc`=0110 and `alu_src`=0 in EXEC/WB; `reg_write`+`pc_write`+`instr_done` in cycle 4; `retired_cnt`=1.
- LOAD with `mem_ready` held low 3 cycles -> `mem_read` high 4 cycles, `alu_cc`=0010, `alu_src`=1; WB has `reg_write`=1, `mem2reg`=1; retires at cycle 8.
- STORE with `mem_ready` never asserted, `MEM_TIMEOUT`=15 -> `mem_write` high 15 cycles, then HALT with `mem_err`=1, `busy`=0, no `instr_done`. Only reset recovers.
- Opcode 1111111 -> `illegal` pulse plus `pc_write` in DECODE, no `reg_write`, `retired_cnt` unchanged. Same result for R-type `funct7`=0100000, `funct3`=111.
- `CNT_W`=4, 16 back-to-back I-ALU instructions with `run` dropped during the 16th -> `retired_cnt` wraps to 0, then the controller enters IDLE with `busy`=0.
